// File: rtl/fetch_stage.sv
// Instruction-fetch stage for the pipelined RV64 core: owns the PC, addresses the
// combinational instruction memory and latches the fetched word into the IF/ID register.
module fetch_stage #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-3:0] imem_addr_o,
    input  logic [31:0]     imem_instr_i,
    output logic [XLEN-1:0] pc_o,
    output logic            if_id_valid_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_pc4_o,
    output logic [31:0]     if_id_instr_o,
    output logic            misalign_o,
    output logic [31:0]     fetch_count_o
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_do_redirect;
    logic            w_do_advance;

    logic [XLEN-1:0] r_pc;
    logic            r_if_id_valid;
    logic [XLEN-1:0] r_if_id_pc;
    logic [XLEN-1:0] r_if_id_pc4;
    logic [31:0]     r_if_id_instr;
    logic            r_misalign;
    logic [31:0]     r_fetch_count;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_redirect_target;
    logic            w_target_misaligned;
    logic            w_count_saturated;

    assign w_pc_plus4          = r_pc + XLEN'(4);
    assign w_redirect_target   = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign w_target_misaligned = |redirect_pc_i[1:0];
    assign w_count_saturated   = &r_fetch_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // BOOT gives the instruction memory one settled cycle; control inputs are ignored there.
    always_comb begin
        w_state_next  = r_state;
        w_do_redirect = 1'b0;
        w_do_advance  = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_i) begin
                    w_do_redirect = 1'b1;
                end else if (!stall_i) begin
                    w_do_advance = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_if_id_valid <= 1'b0;
            r_if_id_pc    <= '0;
            r_if_id_pc4   <= '0;
            r_if_id_instr <= NOP_INSTR;
            r_misalign    <= 1'b0;
            r_fetch_count <= '0;
        end else if (w_do_redirect) begin
            // Bubble keeps the old pc/pc4 fields; only valid and instr are cleared.
            r_pc          <= w_redirect_target;
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= NOP_INSTR;
            if (w_target_misaligned) begin
                r_misalign <= 1'b1;
            end
        end else if (w_do_advance) begin
            r_pc          <= w_pc_plus4;
            r_if_id_valid <= 1'b1;
            r_if_id_pc    <= r_pc;
            r_if_id_pc4   <= w_pc_plus4;
            r_if_id_instr <= imem_instr_i;
            if (!w_count_saturated) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign imem_addr_o   = r_pc[XLEN-1:2];
    assign pc_o          = r_pc;
    assign if_id_valid_o = r_if_id_valid;
    assign if_id_pc_o    = r_if_id_pc;
    assign if_id_pc4_o   = r_if_id_pc4;
    assign if_id_instr_o = r_if_id_instr;
    assign misalign_o    = r_misalign;
    assign fetch_count_o = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a behavioural fetch model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [61:0] imem_addr;
    logic [31:0] imem_instr;
    logic [63:0] pc;
    logic        if_id_valid;
    logic [63:0] if_id_pc;
    logic [63:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        misalign;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int cycle    = 0;

    fetch_stage #(.XLEN(64), .RESET_PC(64'h0), .NOP_INSTR(NOP)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_addr_o   (imem_addr),
        .imem_instr_i  (imem_instr),
        .pc_o          (pc),
        .if_id_valid_o (if_id_valid),
        .if_id_pc_o    (if_id_pc),
        .if_id_pc4_o   (if_id_pc4),
        .if_id_instr_o (if_id_instr),
        .misalign_o    (misalign),
        .fetch_count_o (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: word at word-address a is 0xA0 + a.
    assign imem_instr = 32'hA0 + imem_addr[31:0];

    function automatic logic [31:0] mem_word(input logic [63:0] byte_addr);
        logic [63:0] word_idx;
        word_idx = byte_addr / 64'd4;
        return 32'hA0 + word_idx[31:0];
    endfunction

    // Reference model: what a fetch unit must show after each edge.
    logic [63:0] m_pc, m_ipc, m_ipc4;
    logic [31:0] m_instr;
    logic        m_valid, m_mis;
    longint      m_count;
    int          m_edges_since_reset;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pc                <= 64'h0;
            m_ipc               <= 64'h0;
            m_ipc4              <= 64'h0;
            m_instr             <= NOP;
            m_valid             <= 1'b0;
            m_mis               <= 1'b0;
            m_count             <= 0;
            m_edges_since_reset <= 0;
        end else begin
            m_edges_since_reset <= m_edges_since_reset + 1;
            if (m_edges_since_reset == 0) begin
                // first edge out of reset fetches nothing
            end else if (redirect) begin
                m_pc    <= redirect_pc - (redirect_pc % 64'd4);
                m_valid <= 1'b0;
                m_instr <= NOP;
                m_mis   <= m_mis | ((redirect_pc % 64'd4) != 0);
            end else if (!stall) begin
                m_ipc   <= m_pc;
                m_ipc4  <= m_pc + 64'd4;
                m_pc    <= m_pc + 64'd4;
                m_instr <= mem_word(m_pc);
                m_valid <= 1'b1;
                m_count <= (m_count + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_count + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cycle++;
            $display("cyc %0d rst_n=%0b stall=%0b redir=%0b pc=%h valid=%0b if_pc=%h instr=%h mis=%0b cnt=%0d",
                     cycle, reset_n, stall, redirect, pc, if_id_valid, if_id_pc, if_id_instr, misalign, fetch_count);
            n_checks++;
            if (pc !== m_pc || imem_addr !== m_pc[63:2] || if_id_valid !== m_valid ||
                if_id_pc !== m_ipc || if_id_pc4 !== m_ipc4 || if_id_instr !== m_instr ||
                misalign !== m_mis || fetch_count !== m_count[31:0]) begin
                n_errors++;
                $display("FAIL model_cyc%0d: got pc=%h v=%0b ipc=%h ipc4=%h ins=%h mis=%0b cnt=%0d; want pc=%h v=%0b ipc=%h ipc4=%h ins=%h mis=%0b cnt=%0d",
                         cycle, pc, if_id_valid, if_id_pc, if_id_pc4, if_id_instr, misalign, fetch_count,
                         m_pc, m_valid, m_ipc, m_ipc4, m_instr, m_mis, m_count[31:0]);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pc"},    pc,          64'h0);
        chk({tag, "_valid"}, {63'h0, if_id_valid}, 64'h0);
        chk({tag, "_ipc"},   if_id_pc,    64'h0);
        chk({tag, "_ipc4"},  if_id_pc4,   64'h0);
        chk({tag, "_instr"}, {32'h0, if_id_instr}, {32'h0, NOP});
        chk({tag, "_mis"},   {63'h0, misalign}, 64'h0);
        chk({tag, "_cnt"},   {32'h0, fetch_count}, 64'h0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        #1;
        reset_n = 1'b0;
        chk_en  = 1'b1;

        // 1: reset, boot edge, first fetch
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset0");
        reset_n = 1'b1;
        tick();
        chk("boot_pc", pc, 64'h0);
        chk("boot_valid", {63'h0, if_id_valid}, 64'h0);
        tick();
        chk("first_valid", {63'h0, if_id_valid}, 64'h1);
        chk("first_ipc", if_id_pc, 64'h0);
        chk("first_ipc4", if_id_pc4, 64'h4);
        chk("first_pc", pc, 64'h4);
        chk("stream_instr0", {32'h0, if_id_instr}, 64'hA0);

        // 2: streaming A0..A4
        for (int k = 1; k < 5; k++) begin
            tick();
            chk($sformatf("stream_instr%0d", k), {32'h0, if_id_instr}, 64'hA0 + 64'(k));
        end
        chk("stream_pc", pc, 64'd20);
        chk("stream_cnt", {32'h0, fetch_count}, 64'd5);

        // 3: stall at pc 8
        do_reset();
        tick();
        tick();
        tick();
        chk("pre_stall_pc", pc, 64'h8);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_pc", pc, 64'h8);
            chk("stall_ipc", if_id_pc, 64'h4);
            chk("stall_cnt", {32'h0, fetch_count}, 64'd2);
        end
        stall = 1'b0;
        tick();
        chk("unstall_ipc", if_id_pc, 64'h8);
        chk("unstall_instr", {32'h0, if_id_instr}, 64'hA2);

        // 4: redirect wins over stall on the same edge
        chk("pre_redir_pc", pc, 64'hC);
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'h100;
        tick();
        stall    = 1'b0;
        redirect = 1'b0;
        chk("redir_pc", pc, 64'h100);
        chk("redir_valid", {63'h0, if_id_valid}, 64'h0);
        chk("redir_instr", {32'h0, if_id_instr}, {32'h0, NOP});
        chk("redir_ipc_hold", if_id_pc, 64'h8);
        chk("redir_cnt", {32'h0, fetch_count}, 64'd3);
        tick();
        chk("post_redir_ipc", if_id_pc, 64'h100);
        chk("post_redir_valid", {63'h0, if_id_valid}, 64'h1);
        chk("post_redir_instr", {32'h0, if_id_instr}, 64'hE0);

        // 5: misaligned redirect, sticky through aligned redirects
        redirect    = 1'b1;
        redirect_pc = 64'h203;
        tick();
        chk("mis_pc", pc, 64'h200);
        chk("mis_flag", {63'h0, misalign}, 64'h1);
        redirect_pc = 64'h300;
        tick();
        redirect = 1'b0;
        chk("b2b_pc", pc, 64'h300);
        chk("b2b_valid", {63'h0, if_id_valid}, 64'h0);
        chk("mis_sticky", {63'h0, misalign}, 64'h1);
        tick();
        chk("b2b_ipc", if_id_pc, 64'h300);
        chk("mis_sticky2", {63'h0, misalign}, 64'h1);
        do_reset();

        // 6: PC wrap, then mid-stream asynchronous reset
        tick();
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("wrap_pre_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("wrap_ipc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_ipc4", if_id_pc4, 64'h0);
        chk("wrap_pc", pc, 64'h0);
        chk("wrap_instr", {32'h0, if_id_instr}, 64'h9F);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check_reset_values("async");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        tick();
        chk("restart_ipc", if_id_pc, 64'h0);
        chk("restart_valid", {63'h0, if_id_valid}, 64'h1);
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
